// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store front-end between the multicycle MIPS control/datapath and an
//   asynchronous-read RAM. Registers one request at a time, sequences the RAM
//   read/write strobes, performs byte/halfword stores as read-modify-write,
//   selects and extends load lanes (little-endian), and flags misaligned,
//   out-of-range or illegal-size accesses.
//
//   Optional feature macro: MAU_SUBWORD_EN
//     defined   : byte/half loads and stores supported (RMW path + extension)
//     undefined : size 00/01 answered with an error response; word only
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   req_valid       request present (accepted when req_valid && req_ready)
//   req_ready       high only while idle
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    loads: 1 = zero-extend, 0 = sign-extend
//   req_addr        byte address
//   req_wdata       store data, right-justified
//   resp_valid      one-cycle completion pulse
//   resp_err        error flag, qualified by resp_valid
//   resp_rdata      extended load data (0 for stores and errors)
//   ram_addr        word-aligned byte address to the RAM
//   ram_r, ram_w    RAM read / write strobes (never both high)
//   ram_wdata       RAM write data
//   ram_rdata       RAM read data, combinational from ram_addr/ram_r
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_r,
    output logic              ram_w,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE
`ifdef MAU_SUBWORD_EN
        ,
        ST_RMW_RD,
        ST_RMW_WR
`endif
    } state_e;

    state_e state_q, state_d;

    // Registered outputs
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q,   resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic              ram_r_q,      ram_r_d;
    logic              ram_w_q,      ram_w_d;
    logic [DATA_W-1:0] ram_wdata_q,  ram_wdata_d;

    logic req_err_c;
    logic [DATA_W-1:0] load_data_c;

`ifdef MAU_SUBWORD_EN
    // Request fields needed after accept by the sub-word paths
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q,    size_d;
    logic              uns_q,     uns_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] merge_c;

    // Replace the addressed lane of the old word with the store data
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] data,
        input logic [1:0]        size,
        input logic [1:0]        lo
    );
        logic [DATA_W-1:0] m;
        m = old_w;
        if (size == SZ_BYTE) begin
            case (lo)
                2'd0:    m[7:0]   = data[7:0];
                2'd1:    m[15:8]  = data[7:0];
                2'd2:    m[23:16] = data[7:0];
                default: m[31:24] = data[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            if (lo[1]) m[31:16] = data[15:0];
            else       m[15:0]  = data[15:0];
        end else begin
            m = data;
        end
        return m;
    endfunction

    // Pick the addressed lane of the read word and extend it to 32 bits
    function automatic logic [DATA_W-1:0] extract_lane(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        lo,
        input logic              uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [DATA_W-1:0] r;
        b = 8'(word >> {lo, 3'b000});
        h = 16'(word >> {lo[1], 4'b0000});
        if (size == SZ_BYTE)
            r = uns ? {24'h0, b} : {{24{b[7]}}, b};
        else if (size == SZ_HALF)
            r = uns ? {16'h0, h} : {{16{h[15]}}, h};
        else
            r = word;
        return r;
    endfunction

    assign merge_c     = merge_word(ram_rdata, wdata_q, size_q, addr_lo_q);
    assign load_data_c = extract_lane(ram_rdata, size_q, addr_lo_q, uns_q);
`else
    logic unused_c;
    assign unused_c    = req_unsigned;
    assign load_data_c = ram_rdata;
`endif

    // Acceptance-time legality check
    always_comb begin
        req_err_c = 1'b0;
        if (req_size == SZ_ILL)                          req_err_c = 1'b1;
        if ((req_size == SZ_HALF) && req_addr[0])        req_err_c = 1'b1;
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                                                         req_err_c = 1'b1;
        if (req_addr >= ADDR_W'(MEM_BYTES))              req_err_c = 1'b1;
`ifndef MAU_SUBWORD_EN
        if ((req_size == SZ_BYTE) || (req_size == SZ_HALF))
                                                         req_err_c = 1'b1;
`endif
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            ram_addr_q   <= '0;
            ram_r_q      <= 1'b0;
            ram_w_q      <= 1'b0;
            ram_wdata_q  <= '0;
`ifdef MAU_SUBWORD_EN
            addr_lo_q    <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_r_q      <= ram_r_d;
            ram_w_q      <= ram_w_d;
            ram_wdata_q  <= ram_wdata_d;
`ifdef MAU_SUBWORD_EN
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
`endif
        end
    end

    // Next-state and next-output logic; strobes are computed for the state
    // being entered so they are high for the whole cycle spent in it
    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        ram_addr_d   = ram_addr_q;
        ram_r_d      = 1'b0;
        ram_w_d      = 1'b0;
        ram_wdata_d  = ram_wdata_q;
`ifdef MAU_SUBWORD_EN
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef MAU_SUBWORD_EN
                    addr_lo_d = req_addr[1:0];
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    wdata_d   = req_wdata;
`endif
                    if (req_err_c) begin
                        // Answer immediately, RAM untouched
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        ram_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (!req_we) begin
                            state_d = ST_READ;
                            ram_r_d = 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state_d     = ST_WRITE;
                            ram_w_d     = 1'b1;
                            ram_wdata_d = req_wdata;
                        end else begin
`ifdef MAU_SUBWORD_EN
                            state_d = ST_RMW_RD;
                            ram_r_d = 1'b1;
`endif
                        end
                    end
                end
            end

            ST_READ: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data_c;
                state_d      = ST_IDLE;
            end

            ST_WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end

`ifdef MAU_SUBWORD_EN
            ST_RMW_RD: begin
                // Old word is on ram_rdata now; write back the merged word
                ram_w_d     = 1'b1;
                ram_wdata_d = merge_c;
                state_d     = ST_RMW_WR;
            end

            ST_RMW_WR: begin
                resp_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready_d = (state_d == ST_IDLE);

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign ram_addr   = ram_addr_q;
    assign ram_r      = ram_r_q;
    assign ram_w      = ram_w_q;
    assign ram_wdata  = ram_wdata_q;

endmodule
